// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex 7-segment display driver.
// Scans DIGITS nibbles onto a shared segment bus with one-hot digit enables.
// A new word is loaded into the displayed copy only at frame boundaries, and
// the first cycle of each digit slot is dark to avoid ghosting.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module seg7_scan #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic        INV   = (ACTIVE_LOW != 0);

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
    } disp_t;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    disp_t             pend;
    logic              pend_valid;
    disp_t             shadow;
    disp_t             din;

    logic              cnt_last;
    logic              idx_last;
    logic              boundary;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_lz;
    logic [6:0]        seg_c;
    logic              seg_dp_c;
    logic [DIGITS-1:0] an_c;

    // Hex digit to active-high {a,b,c,d,e,f,g}
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'h7E;
            4'h1:    decode = 7'h30;
            4'h2:    decode = 7'h6D;
            4'h3:    decode = 7'h79;
            4'h4:    decode = 7'h33;
            4'h5:    decode = 7'h5B;
            4'h6:    decode = 7'h5F;
            4'h7:    decode = 7'h70;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h7B;
            4'hA:    decode = 7'h77;
            4'hB:    decode = 7'h1F;
            4'hC:    decode = 7'h4E;
            4'hD:    decode = 7'h3D;
            4'hE:    decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    assign din      = '{value: value, dp: dp, blank: blank};
    assign cnt_last = (cnt == CNT_W'(SCAN_DIV - 1));
    assign idx_last = (idx == IDX_W'(DIGITS - 1));
    assign boundary = cnt_last & idx_last;

    // Select the current digit's shadow fields and build the logical-level outputs
    always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic zero_run;
        zero_run  = 1'b1;
`endif
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        an_c      = '0;
        seg_c     = 7'h00;
        seg_dp_c  = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            zero_run = zero_run & (shadow.value[4*i +: 4] == 4'h0);
`endif
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow.value[4*i +: 4];
                cur_dp    = shadow.dp[i];
                cur_blank = shadow.blank[i];
                an_c[i]   = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                cur_lz    = (i > 0) && zero_run;
`endif
            end
        end
        if (cnt == '0) begin
            an_c = '0;
        end else if (!cur_blank) begin
            seg_c    = cur_lz ? 7'h00 : decode(cur_nib);
            seg_dp_c = cur_dp;
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending/shadow registers: loads reach the display only at frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            pend_valid <= 1'b0;
            shadow     <= '{value: '0, dp: '0, blank: '1};
        end else if (load) begin
            if (boundary) begin
                shadow     <= din;
                pend_valid <= 1'b0;
            end else begin
                pend       <= din;
                pend_valid <= 1'b1;
            end
        end else if (boundary && pend_valid) begin
            shadow     <= pend;
            pend_valid <= 1'b0;
        end
    end

    // Registered pin outputs with polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= {7{INV}};
            seg_dp <= INV;
            an     <= {DIGITS{INV}};
            frame  <= 1'b0;
        end else begin
            seg    <= seg_c ^ {7{INV}};
            seg_dp <= seg_dp_c ^ INV;
            an     <= an_c ^ {DIGITS{INV}};
            frame  <= boundary;
        end
    end

endmodule
